// File: rtl/thinning_window_gen.sv
// thinning_window_gen: streaming 3x3 binary window generator for the thinning kernel.
// Takes a raster-ordered pixel stream, keeps the two previous rows in line buffers and
// emits one zero-padded 3x3 neighbourhood per pixel, in raster order of the center pixel.
// Ports:
//   clk, reset             clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready      input handshake; in_sof marks pixel (0,0), in_pix is the pixel
//   out_valid/out_ready    output handshake
//   top/center/bottom      rows y-1/y/y+1, bit0 = column x-1, bit1 = x, bit2 = x+1
//   out_x/out_y            center coordinates; out_last flags center (WIDTH-1, HEIGHT-1)
module thinning_window_gen #(
  parameter int unsigned WIDTH  = 320,
  parameter int unsigned HEIGHT = 240,
  parameter int unsigned XW     = $clog2(WIDTH),
  parameter int unsigned YW     = $clog2(HEIGHT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sof,
  input  logic          in_pix,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [2:0]    top,
  output logic [2:0]    center,
  output logic [2:0]    bottom,
  output logic [XW-1:0] out_x,
  output logic [YW-1:0] out_y,
  output logic          out_last
);

  typedef enum logic [1:0] {FILL, STREAM, EDGE, FLUSH} state_t;

  state_t          state, state_nx;
  logic [XW-1:0]   x_cnt, x_nx, xm1, xp1, wx;
  logic [YW-1:0]   y_cnt, y_nx;
  logic            x_last, y_last, load_out, xfer;

  // lb_a holds row y-1, lb_b row y-2 (at columns not yet overwritten this row)
  logic [WIDTH-1:0] lb_a, lb_b;
  // Column history per window row: [0] = column x-1, [1] = column x-2
  logic [1:0]       sr_t, sr_c, sr_b;

  logic            win_v, win_last;
  logic [2:0]      win_top, win_ctr, win_bot;
  logic [XW-1:0]   win_x;
  logic [YW-1:0]   win_y;

  assign load_out = !out_valid || out_ready;
  assign in_ready = !reset && load_out && (state == FILL || state == STREAM);
  assign xfer     = in_valid && in_ready;
  assign x_last   = (x_cnt == XW'(WIDTH - 1));
  assign y_last   = (y_cnt == YW'(HEIGHT - 1));
  assign wx       = in_sof ? '0 : x_cnt;

  // State and input position counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FILL;
      x_cnt <= '0;
      y_cnt <= '0;
    end else begin
      state <= state_nx;
      x_cnt <= x_nx;
      y_cnt <= y_nx;
    end
  end

  // Line buffers and column shift registers; contents are masked at borders, so no reset
  always_ff @(posedge clk) begin
    if (xfer) begin
      lb_a[wx] <= in_pix;
      lb_b[wx] <= lb_a[wx];
      sr_t     <= {sr_t[0], lb_b[wx]};
      sr_c     <= {sr_c[0], lb_a[wx]};
      sr_b     <= {sr_b[0], in_pix};
    end
  end

  // Next state, counters and the window to load into the output register
  always_comb begin
    state_nx = state;
    x_nx     = x_cnt;
    y_nx     = y_cnt;
    win_v    = 1'b0;
    win_last = 1'b0;
    win_top  = '0;
    win_ctr  = '0;
    win_bot  = '0;
    win_x    = '0;
    win_y    = '0;
    xm1      = (x_cnt == '0) ? '0 : x_cnt - XW'(1);
    xp1      = x_last ? x_cnt : x_cnt + XW'(1);

    if (xfer && in_sof) begin
      // The sof pixel itself is (0,0); the next one is (1,0)
      state_nx = FILL;
      x_nx     = XW'(1);
      y_nx     = '0;
    end else begin
      case (state)
        FILL: begin
          if (xfer) begin
            if (x_last) begin
              x_nx     = '0;
              y_nx     = YW'(1);
              state_nx = STREAM;
            end else begin
              x_nx = x_cnt + XW'(1);
            end
          end
        end
        STREAM: begin
          if (xfer) begin
            // Pixel (x,y) completes the window centered at (x-1, y-1)
            if (x_cnt != '0) begin
              win_v   = 1'b1;
              win_x   = xm1;
              win_y   = y_cnt - YW'(1);
              win_top = {lb_b[x_cnt], sr_t[0], sr_t[1]};
              win_ctr = {lb_a[x_cnt], sr_c[0], sr_c[1]};
              win_bot = {in_pix, sr_b[0], sr_b[1]};
              if (y_cnt == YW'(1)) win_top = '0;
              if (x_cnt == XW'(1)) begin
                win_top[0] = 1'b0;
                win_ctr[0] = 1'b0;
                win_bot[0] = 1'b0;
              end
            end
            if (x_last) begin
              x_nx     = '0;
              state_nx = EDGE;
            end else begin
              x_nx = x_cnt + XW'(1);
            end
          end
        end
        EDGE: begin
          // Right-most window of row y-1; column x+1 lies outside the image
          if (load_out) begin
            win_v   = 1'b1;
            win_x   = XW'(WIDTH - 1);
            win_y   = y_cnt - YW'(1);
            win_top = (y_cnt == YW'(1)) ? 3'b000 : {1'b0, sr_t[0], sr_t[1]};
            win_ctr = {1'b0, sr_c[0], sr_c[1]};
            win_bot = {1'b0, sr_b[0], sr_b[1]};
            if (y_last) begin
              state_nx = FLUSH;
            end else begin
              y_nx     = y_cnt + YW'(1);
              state_nx = STREAM;
            end
          end
        end
        FLUSH: begin
          // Last row: lb_a holds row HEIGHT-1, lb_b row HEIGHT-2, nothing below
          if (load_out) begin
            win_v   = 1'b1;
            win_x   = x_cnt;
            win_y   = y_cnt;
            win_top = {lb_b[xp1], lb_b[x_cnt], lb_b[xm1]};
            win_ctr = {lb_a[xp1], lb_a[x_cnt], lb_a[xm1]};
            if (x_cnt == '0) begin
              win_top[0] = 1'b0;
              win_ctr[0] = 1'b0;
            end
            if (x_last) begin
              win_top[2] = 1'b0;
              win_ctr[2] = 1'b0;
              win_last   = 1'b1;
              x_nx       = '0;
              y_nx       = '0;
              state_nx   = FILL;
            end else begin
              x_nx = x_cnt + XW'(1);
            end
          end
        end
        default: state_nx = FILL;
      endcase
    end
  end

  // Output register; holds everything while a window waits for out_ready
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      top       <= '0;
      center    <= '0;
      bottom    <= '0;
    end else if (load_out) begin
      out_valid <= win_v;
      out_last  <= win_last;
      if (win_v) begin
        out_x  <= win_x;
        out_y  <= win_y;
        top    <= win_top;
        center <= win_ctr;
        bottom <= win_bot;
      end
    end
  end

endmodule

// File: tb/tb_thinning_window_gen.sv
// Testbench for thinning_window_gen on a 4x3 image: random and directed frames checked
// against a zero-padded neighbourhood model, plus handshake timing and reset behaviour.
module tb_thinning_window_gen;

  localparam int unsigned W  = 4;
  localparam int unsigned H  = 3;
  localparam int unsigned XW = $clog2(W);
  localparam int unsigned YW = $clog2(H);
  localparam int N = W * H;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready, in_sof, in_pix;
  logic          out_valid, out_ready, out_last;
  logic [2:0]    top, center, bottom;
  logic [XW-1:0] out_x;
  logic [YW-1:0] out_y;

  thinning_window_gen #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_pix(in_pix),
    .out_valid(out_valid), .out_ready(out_ready),
    .top(top), .center(center), .bottom(bottom),
    .out_x(out_x), .out_y(out_y), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct { bit pix; bit sof; } pin_t;
  pin_t        pix_q[$];
  logic [31:0] exp_q[$];
  bit          img [H][W];

  bit  cont_valid = 1'b1;
  bit  rand_ready = 1'b0;
  int  hold = 0;
  int  cyc = 0;
  bit  rec = 1'b0;
  int  acc_t[$];
  bit  prev_stall = 1'b0;
  logic [31:0] prev_out = '0;

  function automatic bit p(int x, int y);
    if (x < 0 || x >= int'(W) || y < 0 || y >= int'(H)) return 1'b0;
    return img[y][x];
  endfunction

  // Expected window: {last, y, x, top, center, bottom}, pixels outside the image read 0
  function automatic logic [31:0] win(int cx, int cy);
    logic [2:0] t, c, b;
    for (int k = 0; k < 3; k++) begin
      t[k] = p(cx - 1 + k, cy - 1);
      c[k] = p(cx - 1 + k, cy);
      b[k] = p(cx - 1 + k, cy + 1);
    end
    return 32'({(cx == W - 1 && cy == H - 1), YW'(cy), XW'(cx), t, c, b});
  endfunction

  // Queue n pixels of a frame (kind 0 all ones, 1 single dot at (2,1), 2 random) and the
  // windows that n accepted pixels make visible: a window with center row < H-1 needs the
  // pixel right-below it (clamped to the last column); the last row needs the whole frame.
  task automatic push_frame(input int kind, input bit sof, input int n);
    for (int y = 0; y < int'(H); y++)
      for (int x = 0; x < int'(W); x++)
        img[y][x] = (kind == 0) ? 1'b1 : (kind == 1) ? (x == 2 && y == 1) : 1'($urandom);
    for (int i = 0; i < n; i++)
      pix_q.push_back('{img[i / W][i % W], sof && (i == 0)});
    for (int cy = 0; cy < int'(H); cy++)
      for (int cx = 0; cx < int'(W); cx++) begin
        int trig;
        trig = (cy + 1) * W + ((cx + 1 < int'(W)) ? cx + 1 : int'(W) - 1);
        if ((cy == int'(H) - 1) ? (n == N) : (trig < n)) exp_q.push_back(win(cx, cy));
      end
  endtask

  function automatic int gap_exp(int i);
    int x, y;
    x = i % W;
    y = i / W;
    if (x == int'(W) - 1 && y >= 1) return 2 + ((y == int'(H) - 1) ? int'(W) : 0);
    return 1;
  endfunction

  task automatic cycle();
    logic [31:0] cur, dw;
    @(negedge clk);
    if (pix_q.size() > 0 && (cont_valid || $urandom_range(3) != 0)) begin
      in_valid = 1'b1;
      in_pix   = pix_q[0].pix;
      in_sof   = pix_q[0].sof;
    end else begin
      in_valid = 1'b0;
      in_pix   = 1'($urandom);
      in_sof   = 1'($urandom);
    end
    if (hold > 0) begin
      out_ready = 1'b0;
      hold--;
    end else begin
      out_ready = rand_ready ? ($urandom_range(2) != 0) : 1'b1;
    end
    #1;
    dw  = 32'({out_last, out_y, out_x, top, center, bottom});
    cur = dw | (32'(out_valid) << 31);
    if (prev_stall) check("hold", cur, prev_out);
    if (out_valid && !out_ready) check("stall_rdy", 32'(in_ready), 32'd0);
    prev_stall = out_valid && !out_ready;
    prev_out   = cur;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("win_unexpected", dw, 32'hFFFF_FFFF);
      else check("win", dw, exp_q.pop_front());
    end
    if (in_valid && in_ready) begin
      void'(pix_q.pop_front());
      if (rec) acc_t.push_back(cyc);
    end
    cyc++;
  endtask

  task automatic drain();
    int n = 0;
    while ((pix_q.size() > 0 || exp_q.size() > 0) && n < 3000) begin
      cycle();
      n++;
    end
    check("drain", 32'(pix_q.size() + exp_q.size()), 32'd0);
    repeat (3) cycle();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b1; in_sof = 1'b1; in_pix = 1'b1; out_ready = 1'b0;
    #12;
    check("rst_valid",  32'(out_valid), 32'd0);
    check("rst_last",   32'(out_last),  32'd0);
    check("rst_x",      32'(out_x),     32'd0);
    check("rst_y",      32'(out_y),     32'd0);
    check("rst_top",    32'(top),       32'd0);
    check("rst_center", 32'(center),    32'd0);
    check("rst_bottom", 32'(bottom),    32'd0);
    check("rst_ready",  32'(in_ready),  32'd0);
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; in_sof = 1'b0;

    // All-ones frame then single-dot frame without sof, continuous flow: windows and gaps
    cont_valid = 1'b1; rand_ready = 1'b0; rec = 1'b1;
    push_frame(0, 1'b1, N);
    push_frame(1, 1'b0, N);
    drain();
    rec = 1'b0;
    for (int i = 0; i < 2 * N - 1; i++)
      check("gap", 32'(acc_t[i + 1] - acc_t[i]), 32'(gap_exp(i % N)));

    // Output backpressure for 5 cycles mid-row
    push_frame(2, 1'b1, N);
    repeat (6) cycle();
    hold = 5;
    drain();

    // sof at pixel (2,1) aborts the frame; the restarted frame is complete
    push_frame(2, 1'b1, W + 2);
    push_frame(2, 1'b1, N);
    drain();

    // Random flow control, random aborts (always followed by an sof frame)
    cont_valid = 1'b0; rand_ready = 1'b1;
    begin
      bit need_sof = 1'b1;
      repeat (10) begin
        int n;
        n = ($urandom_range(3) == 0) ? int'($urandom_range(1, N - 1)) : N;
        push_frame(2, need_sof || ($urandom_range(1) == 1), n);
        need_sof = (n < N);
      end
      push_frame(2, 1'b1, N);
    end
    drain();

    // Reset during FLUSH, then a frame without sof
    cont_valid = 1'b1; rand_ready = 1'b0;
    push_frame(2, 1'b1, N);
    begin
      int n = 0;
      while (pix_q.size() > 0 && n < 200) begin
        cycle();
        n++;
      end
    end
    cycle();
    cycle();
    reset = 1'b1;
    #1;
    check("flush_rst_valid", 32'(out_valid), 32'd0);
    check("flush_rst_last",  32'(out_last),  32'd0);
    check("flush_rst_ready", 32'(in_ready),  32'd0);
    exp_q.delete();
    pix_q.delete();
    prev_stall = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    push_frame(2, 1'b0, N);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/thinning_window_gen.md
Name: thinning_window_gen

Overview:
- Streaming 3x3 window generator that feeds the thinning kernel.
- Accepts a raster-ordered stream of binary pixels and holds two previous rows in line buffers.
- Emits exactly one 3x3 neighbourhood (top/center/bottom, 3 bits each) per image pixel, in raster order of the center pixel.
- Pixels outside the image are read as 0.

Parameters:
- WIDTH, 320, pixels per line (>=2).
- HEIGHT, 240, lines per frame (>=2).
- XW, $clog2(WIDTH), column counter width.
- YW, $clog2(HEIGHT), row counter width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block can accept a pixel this cycle.
- in_sof  in  1  start of frame; qualified by in_valid, marks pixel (0,0).
- in_pix  in  1  binary pixel, 1 = foreground.
- out_valid  out  1  window valid.
- out_ready  in  1  downstream accepts window.
- top  out  3  row y-1; bit0 = column x-1, bit1 = x, bit2 = x+1.
- center  out  3  row y, same bit order; center[1] is the pixel under test.
- bottom  out  3  row y+1, same bit order.
- out_x  out  XW  center column.
- out_y  out  YW  center row.
- out_last  out  1  window for center (WIDTH-1, HEIGHT-1).

Behaviour:
- Reset (async): out_valid=0, out_last=0, out_x=0, out_y=0, top/center/bottom=0, in_ready=0 during reset, state=FILL, input counters 0.
- Line buffers and column shift registers are not reset; their contents are masked by the border rules below.
- Input handshake: a pixel transfers when in_valid && in_ready.
- Output handshake: a window transfers when out_valid && out_ready.
- The output register loads only when !out_valid || out_ready. Otherwise all outputs hold and in_ready=0, so the whole pipeline stalls.
- Input transfer at (x,y) with y>=1, x>=1: the next-cycle output is the window for center (x-1, y-1). Latency is 1 cycle.
- Input transfer at (x,0), or at (0,y): no window is produced.
- Border masking:
  - top=0 when center y=0.
  - bottom=0 when center y=HEIGHT-1.
  - bit0 of all rows = 0 when center x=0.
  - bit2 of all rows = 0 when center x=WIDTH-1.
- States:
  - FILL: row 0. in_ready=1 (subject to stall), no windows emitted. After pixel (WIDTH-1,0) -> STREAM.
  - STREAM: rows 1..HEIGHT-1. Emits windows as above. After pixel (WIDTH-1,y) -> EDGE.
  - EDGE: one cycle with in_ready=0. Emits center (WIDTH-1, y-1) with the right column masked. Then -> STREAM if y<HEIGHT-1, else -> FLUSH.
  - FLUSH: in_ready=0. Emits WIDTH windows for row HEIGHT-1 with bottom=0, x=0..WIDTH-1, one per output transfer. out_last=1 on the final window. Then -> FILL with counters cleared.
- in_sof is honoured in any state and in the same cycle as the pixel transfer:
  - Counters and state are forced so that the pixel is taken as (0,0) in FILL.
  - Any partial frame is discarded without flush.
  - A pending, unaccepted output window is still held until out_ready.
- in_sof is not required at frame start: after FILL re-entry, the next pixel is (0,0).
- Exactly WIDTH*HEIGHT windows are produced per complete frame.
- Counter wrap: x wraps WIDTH-1 -> 0 and increments y. y never exceeds HEIGHT-1.
- Reset asserted mid-frame: outputs drop to their reset values immediately, and the frame in progress is lost.

Test Plan:
- WIDTH=4, HEIGHT=3, all-ones frame, out_ready=1 -> 12 windows in raster order.
  - Center (0,0): top=000, center=110, bottom=110.
  - Center (1,1): all rows 111.
  - Center (3,2): top=011, center=011, bottom=000, out_last=1.
- Single 1 at (2,1), other pixels 0 -> only windows with centers (1..3, 0..2) show the 1, each at the correct bit position. All windows elsewhere are 000.
- Backpressure: hold out_ready=0 for 5 cycles mid-row -> in_ready=0 and outputs stable throughout. On release, the stream resumes with no lost or duplicated window (12 total).
- EDGE/FLUSH timing: continuous in_valid -> in_ready=0 exactly one cycle after each line end in rows 1..2, and for 4 cycles during FLUSH.
- in_sof asserted at pixel (2,1) of frame 1 -> counters restart at (0,0). Frame 2 then yields 12 correct windows, and no out_last is issued for frame 1.
- Reset asserted during FLUSH -> out_valid=0 the same cycle. After release, a new frame produces the full 12 windows.
